// File: rtl/trace_monitor_pkg.sv
// Shared constants and types for the multi-core trace termination monitor.
// Holds the l.nop hook encodings and the per-core trace slice layout.
package trace_monitor_pkg;

  localparam logic [15:0] L_NOP_HI = 16'h1500;
  localparam logic [15:0] NOP_EXIT = 16'h0001;
  localparam logic [15:0] NOP_PUTC = 16'h0004;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } trace_slice_t;

  typedef enum logic {
    CORE_RUN    = 1'b0,
    CORE_EXITED = 1'b1
  } core_state_e;

  function automatic logic is_hook(input logic [31:0] insn, input logic [15:0] code);
    return (insn[31:16] == L_NOP_HI) && (insn[15:0] == code);
  endfunction

endpackage

// File: rtl/trace_core_tracker.sv
// One core's view: r3 shadow, RUN/EXITED state, hook decode, character FIFO
// with overflow flag, and a pop port used by the top-level arbiter.
module trace_core_tracker
  import trace_monitor_pkg::*;
#(
  parameter int CHAR_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  trace_slice_t trace_i,
  input  logic         pop_i,
  output logic         active_o,
  output logic         empty_o,
  output logic [7:0]   head_o,
  output logic         exited_o,
  output logic [31:0]  exit_code_o,
  output logic         overflow_o
);

  localparam int AW = $clog2(CHAR_FIFO_DEPTH);

  core_state_e state_q, state_d;
  logic [31:0] r3_q;
  logic [31:0] exit_code_q;
  logic        overflow_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  fifo_mem [CHAR_FIFO_DEPTH];

  logic hook_exit, hook_putc, full, push, pop;

  assign active_o  = trace_i.valid && (state_q == CORE_RUN);
  assign hook_exit = active_o && is_hook(trace_i.insn, NOP_EXIT);
  assign hook_putc = active_o && is_hook(trace_i.insn, NOP_PUTC);

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign push    = hook_putc && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) state_q <= CORE_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_RUN:    if (hook_exit) state_d = CORE_EXITED;
      CORE_EXITED: state_d = CORE_EXITED;
    endcase
  end

  always_comb begin
    exited_o = (state_q == CORE_EXITED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_q        <= '0;
      exit_code_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (active_o && trace_i.wben && (trace_i.wbreg == 5'd3)) r3_q <= trace_i.wbdata;
      if (hook_exit) exit_code_q <= r3_q;
      if (hook_putc && !push) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= r3_q[7:0];
  end

  assign head_o      = fifo_mem[rd_ptr_q[AW-1:0]];
  assign exit_code_o = exit_code_q;
  assign overflow_o  = overflow_q;

endmodule

// File: rtl/trace_term_monitor.sv
// Multi-core trace checker: per-core trackers, round-robin console merge into
// one registered output slot, cross-core termination and retirement-stall timeout.
module trace_term_monitor
  import trace_monitor_pkg::*;
#(
  parameter int NUM_CORES       = 1,
  parameter int TERM_CROSS_NUM  = NUM_CORES,
  parameter int CHAR_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    trace_valid,
  input  logic [NUM_CORES*32-1:0] trace_insn,
  input  logic [NUM_CORES-1:0]    trace_wben,
  input  logic [NUM_CORES*5-1:0]  trace_wbreg,
  input  logic [NUM_CORES*32-1:0] trace_wbdata,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic [7:0]              char_data,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] char_core,
  output logic [NUM_CORES-1:0]    core_exited,
  output logic [NUM_CORES*32-1:0] exit_code,
  output logic [NUM_CORES-1:0]    char_overflow,
  output logic                    all_done,
  output logic                    timeout
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PW = $clog2(NUM_CORES + 1);

  logic [NUM_CORES-1:0] core_active, fifo_empty, pop;
  logic [7:0]           head [NUM_CORES];

  logic          slot_valid_q;
  logic [7:0]    slot_data_q;
  logic [CW-1:0] slot_core_q;
  logic [CW-1:0] rr_ptr_q;
  logic          all_done_q;

  logic          slot_load, grant_valid, found_hi, found_lo;
  logic [CW-1:0] grant_idx, idx_hi, idx_lo;
  logic [7:0]    grant_data;
  logic [PW-1:0] exit_cnt;
  logic          done_cond;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    trace_slice_t slice;
    assign slice = '{valid:  trace_valid[gi],
                     insn:   trace_insn[gi*32 +: 32],
                     wben:   trace_wben[gi],
                     wbreg:  trace_wbreg[gi*5 +: 5],
                     wbdata: trace_wbdata[gi*32 +: 32]};

    trace_core_tracker #(.CHAR_FIFO_DEPTH(CHAR_FIFO_DEPTH)) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .trace_i     (slice),
      .pop_i       (pop[gi]),
      .active_o    (core_active[gi]),
      .empty_o     (fifo_empty[gi]),
      .head_o      (head[gi]),
      .exited_o    (core_exited[gi]),
      .exit_code_o (exit_code[gi*32 +: 32]),
      .overflow_o  (char_overflow[gi])
    );

    assign pop[gi] = grant_valid && (grant_idx == CW'(gi));
  end

  assign slot_load = !slot_valid_q || char_ready;

  // rr_ptr_q is the first core to consider; wrap to the lowest index when
  // nothing at or above it is pending.
  always_comb begin
    found_hi    = 1'b0;
    found_lo    = 1'b0;
    idx_hi      = '0;
    idx_lo      = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (!fifo_empty[j] && !found_hi && (j >= int'(rr_ptr_q))) begin
        found_hi = 1'b1;
        idx_hi   = CW'(j);
      end
      if (!fifo_empty[j] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = CW'(j);
      end
    end
    if (slot_load) begin
      grant_valid = found_hi || found_lo;
      grant_idx   = found_hi ? idx_hi : idx_lo;
    end
    for (int j = 0; j < NUM_CORES; j++) begin
      if (CW'(j) == grant_idx) grant_data = head[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_core_q  <= '0;
      rr_ptr_q     <= '0;
    end else if (slot_load) begin
      slot_valid_q <= grant_valid;
      if (grant_valid) begin
        slot_data_q <= grant_data;
        slot_core_q <= grant_idx;
        rr_ptr_q    <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + CW'(1);
      end
    end
  end

  always_comb begin
    exit_cnt = '0;
    for (int j = 0; j < NUM_CORES; j++) exit_cnt = exit_cnt + PW'(core_exited[j]);
  end

  assign done_cond = (int'(exit_cnt) >= TERM_CROSS_NUM) && (&fifo_empty) && !slot_valid_q;

  always_ff @(posedge clk) begin
    if (rst) all_done_q <= 1'b0;
    else     all_done_q <= all_done_q || done_cond;
  end

  if (TIMEOUT_CYCLES != 0) begin : g_stall
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q;

    always_comb begin
      if (|core_active)                         stall_d = '0;
      else if (stall_q == SW'(TIMEOUT_CYCLES))  stall_d = stall_q;
      else                                      stall_d = stall_q + SW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stall_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        stall_q   <= stall_d;
        timeout_q <= timeout_q || ((stall_d == SW'(TIMEOUT_CYCLES)) && !all_done_q);
      end
    end

    assign timeout = timeout_q;
  end else begin : g_no_stall
    assign timeout = 1'b0;
  end

  assign char_valid = slot_valid_q;
  assign char_data  = slot_data_q;
  assign char_core  = slot_core_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_trace_term_monitor.sv
// Bench for trace_term_monitor: a 3-core instance checked every cycle against
// a list-based model, plus a 1-core instance with literal expectations.
module tb_trace_term_monitor;

  localparam int N = 3;
  localparam logic [31:0] ADDI = 32'h9c60_0000;
  localparam logic [31:0] EXIT = 32'h1500_0001;
  localparam logic [31:0] PUTC = 32'h1500_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N-1:0] tv, twe;
  logic [31:0]  ti [N];
  logic [31:0]  twd [N];
  logic [4:0]   twr [N];
  logic [N*32-1:0] insn_f, wbd_f;
  logic [N*5-1:0]  wbr_f;
  logic         ready;
  logic         cv, ad, to;
  logic [7:0]   cd;
  logic [1:0]   cc;
  logic [N-1:0] ce, ov;
  logic [N*32-1:0] ec;

  always_comb begin
    insn_f = '0; wbd_f = '0; wbr_f = '0;
    for (int c = 0; c < N; c++) begin
      insn_f[c*32 +: 32] = ti[c];
      wbd_f[c*32 +: 32]  = twd[c];
      wbr_f[c*5 +: 5]    = twr[c];
    end
  end

  trace_term_monitor #(.NUM_CORES(N), .TERM_CROSS_NUM(2), .CHAR_FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) u_dut (
    .clk(clk), .rst(rst), .trace_valid(tv), .trace_insn(insn_f), .trace_wben(twe),
    .trace_wbreg(wbr_f), .trace_wbdata(wbd_f), .char_valid(cv), .char_ready(ready),
    .char_data(cd), .char_core(cc), .core_exited(ce), .exit_code(ec),
    .char_overflow(ov), .all_done(ad), .timeout(to));

  logic        s_tv, s_twe, s_ready, s_cv, s_cc, s_ce, s_ov, s_ad, s_to;
  logic [31:0] s_ti, s_twd, s_ec;
  logic [4:0]  s_twr;
  logic [7:0]  s_cd;

  trace_term_monitor #(.NUM_CORES(1), .TERM_CROSS_NUM(1), .CHAR_FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .trace_valid(s_tv), .trace_insn(s_ti), .trace_wben(s_twe),
    .trace_wbreg(s_twr), .trace_wbdata(s_twd), .char_valid(s_cv), .char_ready(s_ready),
    .char_data(s_cd), .char_core(s_cc), .core_exited(s_ce), .exit_code(s_ec),
    .char_overflow(s_ov), .all_done(s_ad), .timeout(s_to));

  int total = 0;
  int bad = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-core character lists, round-robin merge, exit counting.
  bit          m_cv, m_done, m_to;
  logic [7:0]  m_cd;
  int          m_cc, m_next, m_stall;
  logic [31:0] m_r3 [N];
  logic [31:0] m_code [N];
  logic [N-1:0] m_ex, m_ov;
  logic [7:0]  m_buf [N][4];
  int          m_n [N];
  int          md_cnt, md_c;
  bit          md_cond, md_any, md_done_old;

  always @(posedge clk) begin
    if (rst) begin
      m_cv = 0; m_cd = 0; m_cc = 0; m_next = 0; m_ex = 0; m_ov = 0;
      m_done = 0; m_to = 0; m_stall = 0;
      for (int c = 0; c < N; c++) begin m_r3[c] = 0; m_code[c] = 0; m_n[c] = 0; end
    end else begin
      md_cnt = 0; md_cond = 1; md_any = 0; md_done_old = m_done;
      for (int c = 0; c < N; c++) begin
        md_cnt += int'(m_ex[c]);
        if (m_n[c] != 0) md_cond = 0;
        if (tv[c] && !m_ex[c]) md_any = 1;
      end
      md_cond = md_cond && (md_cnt >= 2) && !m_cv;
      if (!m_cv || ready) begin
        m_cv = 0;
        for (int k = 0; k < N; k++) begin
          md_c = (m_next + k) % N;
          if (!m_cv && m_n[md_c] > 0) begin
            m_cv = 1; m_cd = m_buf[md_c][0]; m_cc = md_c; m_next = (md_c + 1) % N;
            for (int i = 0; i < 3; i++) m_buf[md_c][i] = m_buf[md_c][i+1];
            m_n[md_c]--;
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        if (tv[c] && !m_ex[c]) begin
          if (ti[c] == EXIT) begin m_code[c] = m_r3[c]; m_ex[c] = 1; end
          if (ti[c] == PUTC) begin
            if (m_n[c] < 4) begin m_buf[c][m_n[c]] = m_r3[c][7:0]; m_n[c]++; end
            else m_ov[c] = 1;
          end
          if (twe[c] && twr[c] == 5'd3) m_r3[c] = twd[c];
        end
      end
      if (md_cond) m_done = 1;
      if (md_any) m_stall = 0;
      else if (m_stall < 100) m_stall++;
      if (m_stall == 100 && !md_done_old) m_to = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("char_valid", 32'(cv), 32'(m_cv));
      if (m_cv) begin
        chk("char_data", 32'(cd), 32'(m_cd));
        chk("char_core", 32'(cc), 32'(m_cc));
      end
      chk("core_exited", 32'(ce), 32'(m_ex));
      chk("char_overflow", 32'(ov), 32'(m_ov));
      chk("all_done", 32'(ad), 32'(m_done));
      chk("timeout", 32'(to), 32'(m_to));
      for (int c = 0; c < N; c++) chk("exit_code", ec[c*32 +: 32], m_code[c]);
    end
  end

  logic [9:0] rx [$];
  logic [9:0] exp_rx [$];
  logic [7:0] rx1 [$];

  always @(negedge clk) begin
    if (started && !rst && cv === 1'b1 && ready) begin
      rx.push_back({cc, cd});
      $display("char core=%0d data=%02h", cc, cd);
    end
    if (started && !rst && s_cv === 1'b1 && s_ready) begin
      rx1.push_back(s_cd);
      $display("char1 data=%02h", s_cd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tv = '0; twe = '0; s_tv = 0; s_twe = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_insn(input int c, input logic [31:0] insn, input logic we, input logic [31:0] d);
    tv[c] = 1'b1; ti[c] = insn; twe[c] = we; twr[c] = 5'd3; twd[c] = d;
  endtask

  task automatic set_s(input logic [31:0] insn, input logic we, input logic [31:0] d);
    s_tv = 1; s_ti = insn; s_twe = we; s_twr = 5'd3; s_twd = d;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic add_exp(input int c, input logic [7:0] d);
    exp_rx.push_back({2'(c), d});
  endtask

  task automatic check_rx(input string nm);
    chk({nm, "_count"}, 32'(rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < rx.size() && i < exp_rx.size(); i++) chk({nm, "_item"}, 32'(rx[i]), 32'(exp_rx[i]));
    rx.delete(); exp_rx.delete();
  endtask

  initial begin
    rst = 1; tv = '0; twe = '0; ready = 0;
    for (int c = 0; c < N; c++) begin ti[c] = '0; twd[c] = '0; twr[c] = '0; end
    s_tv = 0; s_twe = 0; s_ti = '0; s_twd = '0; s_twr = '0; s_ready = 0;
    tick();
    started = 1;
    tick();
    rst = 0;
    chk("reset_char_valid", 32'(cv), 32'd0);
    chk("reset_exited", 32'(ce), 32'd0);
    chk("reset_all_done", 32'(ad), 32'd0);
    chk("reset_timeout", 32'(to), 32'd0);

    // Simultaneous putc pairs from cores 0 and 1
    ready = 1;
    set_insn(0, ADDI, 1, 32'h41); set_insn(1, ADDI, 1, 32'h42); tick();
    set_insn(0, PUTC, 0, 0); set_insn(1, PUTC, 0, 0); tick();
    idle(4);
    set_insn(0, PUTC, 0, 0); set_insn(1, PUTC, 0, 0); tick();
    idle(4);
    add_exp(0, 8'h41); add_exp(1, 8'h42); add_exp(0, 8'h41); add_exp(1, 8'h42);
    check_rx("pair_rx");

    // Overflow: six back-to-back putcs with the sink stalled
    do_reset();
    ready = 0;
    set_insn(0, ADDI, 1, 32'h61); tick();
    for (int i = 0; i < 6; i++) begin set_insn(0, PUTC, 1, 32'h62 + 32'(i)); tick(); end
    idle(2);
    chk("ovf_hold_valid", 32'(cv), 32'd1);
    chk("ovf_hold_data", 32'(cd), 32'h61);
    chk("ovf_flag", 32'(ov), 32'b001);
    ready = 1;
    idle(8);
    for (int i = 0; i < 5; i++) add_exp(0, 8'h61 + 8'(i));
    check_rx("ovf_rx");

    // Cross-core termination with TERM_CROSS_NUM=2
    do_reset();
    set_insn(0, ADDI, 1, 32'd7); tick();
    set_insn(0, EXIT, 0, 0); tick();
    idle(3);
    chk("one_exit_not_done", 32'(ad), 32'd0);
    set_insn(2, ADDI, 1, 32'd0); tick();
    set_insn(2, EXIT, 0, 0); tick();
    chk("exited_mask", 32'(ce), 32'b101);
    chk("done_not_yet", 32'(ad), 32'd0);
    tick();
    chk("done_after_exit", 32'(ad), 32'd1);
    chk("exit_code0", ec[31:0], 32'd7);
    set_insn(0, ADDI, 1, 32'h99); tick();
    set_insn(0, EXIT, 0, 0); tick();
    set_insn(0, PUTC, 0, 0); tick();
    idle(3);
    chk("post_exit_code0", ec[31:0], 32'd7);
    check_rx("post_exit_rx");

    // Stall timeout with no retirement, then with one retirement at cycle 50
    do_reset();
    idle(99);
    chk("timeout_at_99", 32'(to), 32'd0);
    tick();
    chk("timeout_at_100", 32'(to), 32'd1);
    do_reset();
    idle(49);
    set_insn(1, ADDI, 0, 0); tick();
    idle(99);
    chk("timeout_at_149", 32'(to), 32'd0);
    tick();
    chk("timeout_at_150", 32'(to), 32'd1);

    // Reset while the output is stalled and cores have exited
    do_reset();
    ready = 0;
    set_insn(0, ADDI, 1, 32'h78); tick();
    for (int i = 0; i < 3; i++) begin set_insn(0, PUTC, 1, 32'h79 + 32'(i)); tick(); end
    set_insn(1, EXIT, 0, 0); tick();
    idle(2);
    chk("pre_rst_valid", 32'(cv), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rst_valid", 32'(cv), 32'd0);
    chk("rst_exited", 32'(ce), 32'd0);
    chk("rst_exit_code", ec[31:0] | ec[63:32] | ec[95:64], 32'd0);
    chk("rst_overflow", 32'(ov), 32'd0);
    idle(3);
    ready = 1;
    idle(3);
    chk("rst_fifo_empty", 32'(cv), 32'd0);
    check_rx("rst_rx");

    // Single-core instance: hello, exit, timeout disabled
    do_reset();
    s_ready = 1;
    set_s(ADDI, 1, 32'h48); tick();
    set_s(PUTC, 0, 0); tick();
    set_s(ADDI, 1, 32'h69); tick();
    set_s(PUTC, 0, 0); tick();
    idle(3);
    chk("one_core_count", 32'(rx1.size()), 32'd2);
    if (rx1.size() == 2) begin
      chk("one_core_c0", 32'(rx1[0]), 32'h48);
      chk("one_core_c1", 32'(rx1[1]), 32'h69);
    end
    chk("one_core_src", 32'(s_cc), 32'd0);
    set_s(ADDI, 1, 32'd0); tick();
    set_s(EXIT, 0, 0); tick();
    idle(2);
    chk("one_core_exited", 32'(s_ce), 32'd1);
    chk("one_core_code", s_ec, 32'd0);
    chk("one_core_done", 32'(s_ad), 32'd1);
    do_reset();
    idle(120);
    chk("one_core_no_timeout", 32'(s_to), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
